// File: rtl/sphere_dfs_prune.sv
// sphere_dfs_prune
// Depth-first sphere-decoder tree search over a 4-level, M-ary tree
// (M = 2**SYM_BITS). One node is visited per cycle. metric_calc supplies the
// cumulative partial distance of that node combinationally.
// Subtrees are pruned against a radius that shrinks on every better leaf.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   Start               begin a search (ignored while a search is running)
//   InitRadius          initial squared radius, latched at Start
//   NodeCost            partial distance of (S_3..S_0, NodeLvl), same cycle
//   S_0..S_3, NodeLvl   current node presented to metric_calc
//   Busy, Done          search running / one-cycle end-of-search pulse
//   Found               at least one leaf was accepted
//   BestS_0..3,BestCost best symbol vector and its cost
//   NodeCount           nodes visited, saturating
//
// state | meaning
// IDLE  | waiting for Start; results of the last search held
// VISIT | evaluate one node per cycle: prune, accept leaf, or descend
// DONE  | one-cycle Done pulse; tree exhausted
module sphere_dfs_prune #(
  parameter int WIDTH     = 32,
  parameter int SYM_BITS  = 3,
  parameter int PRUNE     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     InitRadius,
  input  logic [WIDTH-1:0]     NodeCost,
  output logic [SYM_BITS-1:0]  S_0,
  output logic [SYM_BITS-1:0]  S_1,
  output logic [SYM_BITS-1:0]  S_2,
  output logic [SYM_BITS-1:0]  S_3,
  output logic [1:0]           NodeLvl,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Found,
  output logic [SYM_BITS-1:0]  BestS_0,
  output logic [SYM_BITS-1:0]  BestS_1,
  output logic [SYM_BITS-1:0]  BestS_2,
  output logic [SYM_BITS-1:0]  BestS_3,
  output logic [WIDTH-1:0]     BestCost,
  output logic [CNT_WIDTH-1:0] NodeCount
);

  typedef enum logic [1:0] {IDLE, VISIT, DONE} state_e;

  localparam logic [SYM_BITS-1:0] SYM_MAX = '1;

  state_e                      state_q, state_d;
  logic [3:0][SYM_BITS-1:0]    s_q, s_d;
  logic [3:0][SYM_BITS-1:0]    best_s_q, best_s_d;
  logic [1:0]                  lvl_q, lvl_d;
  logic [WIDTH-1:0]            radius_q, radius_d;
  logic [WIDTH-1:0]            best_cost_q, best_cost_d;
  logic                        found_q, found_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

  logic                        is_leaf;
  logic                        do_prune;
  logic                        adv_ok;
  logic [1:0]                  adv_k;

  assign is_leaf  = (lvl_q == 2'd0);
  assign do_prune = (PRUNE != 0) && !is_leaf && (NodeCost >= radius_q);

  // Backtrack target: lowest level at or above the current one that still
  // has an untried sibling. Scanning downward leaves the smallest k.
  always_comb begin
    adv_ok = 1'b0;
    adv_k  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (k >= int'(lvl_q) && s_q[k] != SYM_MAX) begin
        adv_ok = 1'b1;
        adv_k  = 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    best_s_d    = best_s_q;
    lvl_d       = lvl_q;
    radius_d    = radius_q;
    best_cost_d = best_cost_q;
    found_d     = found_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d     = VISIT;
          radius_d    = InitRadius;
          s_d         = '0;
          lvl_d       = 2'd3;
          found_d     = 1'b0;
          best_cost_d = '1;
          best_s_d    = '0;
          cnt_d       = '0;
        end
      end
      VISIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (do_prune || is_leaf) begin
          // Strict compare: an equal-cost leaf loses to the one found first.
          if (is_leaf && NodeCost < radius_q) begin
            radius_d    = NodeCost;
            best_cost_d = NodeCost;
            best_s_d    = s_q;
            found_d     = 1'b1;
          end
          if (adv_ok) begin
            for (int j = 0; j < 4; j++) begin
              if (j < int'(adv_k)) s_d[j] = '0;
            end
            s_d[adv_k] = s_q[adv_k] + SYM_BITS'(1);
            lvl_d      = adv_k;
          end else begin
            state_d = DONE;
          end
        end else begin
          lvl_d              = lvl_q - 2'd1;
          s_d[lvl_q - 2'd1]  = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      best_s_q    <= '0;
      lvl_q       <= 2'd3;
      radius_q    <= '1;
      best_cost_q <= '1;
      found_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      best_s_q    <= best_s_d;
      lvl_q       <= lvl_d;
      radius_q    <= radius_d;
      best_cost_q <= best_cost_d;
      found_q     <= found_d;
      cnt_q       <= cnt_d;
    end
  end

  assign S_0       = s_q[0];
  assign S_1       = s_q[1];
  assign S_2       = s_q[2];
  assign S_3       = s_q[3];
  assign NodeLvl   = lvl_q;
  assign Busy      = (state_q == VISIT);
  assign Done      = (state_q == DONE);
  assign Found     = found_q;
  assign BestS_0   = best_s_q[0];
  assign BestS_1   = best_s_q[1];
  assign BestS_2   = best_s_q[2];
  assign BestS_3   = best_s_q[3];
  assign BestCost  = best_cost_q;
  assign NodeCount = cnt_q;

endmodule
